// File: rtl/montgomery_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : montgomery_exp_ctrl
// Brief   : Left-to-right square-and-multiply sequencer for an external
//           Montgomery multiplier; returns x^e mod M in the normal domain.
// Rev     : 1.0
// ============================================================================
module montgomery_exp_ctrl #(
  parameter int WIDTH   = 1024,
  parameter int E_WIDTH = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [WIDTH-1:0]               in_x,
  input  logic [WIDTH-1:0]               in_r,
  input  logic [WIDTH-1:0]               in_m,
  input  logic [E_WIDTH-1:0]             in_e,
  input  logic [$clog2(E_WIDTH+1)-1:0]   e_len,
  output logic                           mul_start,
  output logic [WIDTH-1:0]               mul_a,
  output logic [WIDTH-1:0]               mul_b,
  output logic [WIDTH-1:0]               mul_m,
  input  logic [WIDTH-1:0]               mul_result,
  input  logic                           mul_done,
  output logic [WIDTH-1:0]               result,
  output logic                           done,
  output logic                           busy
);

  localparam int c_len_w = $clog2(E_WIDTH + 1);
  localparam int c_idx_w = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

  localparam logic [c_len_w-1:0] c_e_max   = c_len_w'(E_WIDTH);
  localparam logic [c_len_w-1:0] c_len_one = c_len_w'(1);
  localparam logic [c_idx_w-1:0] c_idx_one = c_idx_w'(1);
  localparam logic [WIDTH-1:0]   c_one     = WIDTH'(1);

  localparam logic [3:0] c_idle       = 4'd0;
  localparam logic [3:0] c_sqr_issue  = 4'd1;
  localparam logic [3:0] c_sqr_wait   = 4'd2;
  localparam logic [3:0] c_mul_issue  = 4'd3;
  localparam logic [3:0] c_mul_wait   = 4'd4;
  localparam logic [3:0] c_next       = 4'd5;
  localparam logic [3:0] c_post_issue = 4'd6;
  localparam logic [3:0] c_post_wait  = 4'd7;
  localparam logic [3:0] c_done       = 4'd8;

  logic [3:0]         r_state;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_m;
  logic [E_WIDTH-1:0] r_e;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic [c_idx_w-1:0] r_idx;
  logic [WIDTH-1:0]   r_result;

  logic [c_len_w-1:0] w_len;
  logic               w_ebit;

  assign w_len  = (e_len > c_e_max) ? c_e_max : e_len;
  assign w_ebit = r_e[r_idx];

  // Operand B is loaded on entry to each issue state so the multiplier
  // sees constant operands for the whole issue/wait window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_idle;
      r_x      <= '0;
      r_m      <= '0;
      r_e      <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_idx    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_x   <= in_x;
            r_m   <= in_m;
            r_e   <= in_e;
            r_acc <= in_r;
            r_idx <= c_idx_w'(w_len - c_len_one);
            if (w_len == '0) begin
              r_opb   <= c_one;
              r_state <= c_post_issue;
            end else begin
              r_opb   <= in_r;
              r_state <= c_sqr_issue;
            end
          end
        end
        c_sqr_issue: r_state <= c_sqr_wait;
        c_sqr_wait: begin
          if (mul_done) begin
            r_acc <= mul_result;
            if (w_ebit) begin
              r_opb   <= r_x;
              r_state <= c_mul_issue;
            end else begin
              r_state <= c_next;
            end
          end
        end
        c_mul_issue: r_state <= c_mul_wait;
        c_mul_wait: begin
          if (mul_done) begin
            r_acc   <= mul_result;
            r_state <= c_next;
          end
        end
        c_next: begin
          if (r_idx == '0) begin
            r_opb   <= c_one;
            r_state <= c_post_issue;
          end else begin
            r_idx   <= r_idx - c_idx_one;
            r_opb   <= r_acc;
            r_state <= c_sqr_issue;
          end
        end
        c_post_issue: r_state <= c_post_wait;
        c_post_wait: begin
          if (mul_done) begin
            r_result <= mul_result;
            r_state  <= c_done;
          end
        end
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  assign mul_start = (r_state == c_sqr_issue) || (r_state == c_mul_issue) ||
                     (r_state == c_post_issue);
  assign mul_a     = r_acc;
  assign mul_b     = r_opb;
  assign mul_m     = r_m;
  assign result    = r_result;
  assign done      = (r_state == c_done);
  assign busy      = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_montgomery_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_montgomery_exp_ctrl
// Brief   : Self-checking bench with a latency-programmable Montgomery
//           multiplier model and a modular-exponentiation reference.
// Rev     : 1.0
// ============================================================================
module tb_montgomery_exp_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_x = '0, in_r = '0, in_m = '0, in_e = '0;
  logic [3:0] e_len = '0;
  logic       mul_start;
  logic [7:0] mul_a, mul_b, mul_m;
  logic [7:0] mul_result = '0;
  logic       mul_done = 1'b0;
  logic [7:0] result;
  logic       done, busy;

  always #5 clk = ~clk;

  montgomery_exp_ctrl #(.WIDTH(8), .E_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_r(in_r), .in_m(in_m), .in_e(in_e), .e_len(e_len),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_result(mul_result), .mul_done(mul_done),
    .result(result), .done(done), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Mont(a,b) = a*b*256^-1 mod m
  function automatic int mont(input int a, input int b, input int m);
    int inv = 0;
    for (int k = 1; k < m; k++) if ((256 * k) % m == 1) inv = k;
    return ((a * b) % m) * inv % m;
  endfunction

  function automatic int eff_len(input int len);
    return (len > 8) ? 8 : len;
  endfunction

  function automatic int pow_mod(input int x, input int e, input int len, input int m);
    int r = 1 % m;
    int b = x % m;
    for (int i = 0; i < eff_len(len); i++) begin
      if (((e >> i) & 1) != 0) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r;
  endfunction

  function automatic int pop_len(input int e, input int len);
    int c = 0;
    for (int i = 0; i < eff_len(len); i++) if (((e >> i) & 1) != 0) c++;
    return c;
  endfunction

  // Reference expectations for the operation in flight
  int exp_result = 0, exp_starts = 0, exp_m = 0;
  bit lat_rand = 1'b0, glitch_en = 1'b0;

  // Multiplier model: captures operands on mul_start, answers after a latency
  initial begin : mult_model
    int         cnt;
    bit         pend;
    logic [7:0] res;
    cnt = 0; pend = 1'b0; res = '0;
    forever begin
      @(posedge clk); #1;
      mul_done = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          mul_done   = 1'b1;
          mul_result = res;
          pend       = 1'b0;
        end
      end else if (glitch_en && $urandom_range(0, 2) == 0) begin
        mul_done   = 1'b1;
        mul_result = 8'($urandom);
      end
      if (mul_start === 1'b1 && !pend) begin
        pend = 1'b1;
        cnt  = lat_rand ? int'($urandom_range(1, 40)) : 3;
        res  = 8'(mont(int'(mul_a), int'(mul_b), int'(mul_m)));
      end
    end
  end

  // Compare process: owns all observation state
  int          n_starts = 0, n_done = 0, held = 0;
  bit          in_flight = 1'b0, prev_done = 1'b0;
  logic [23:0] cap = '0;
  int          seq_a [8];
  int          seq_b [8];

  always @(negedge clk) begin
    if (reset) begin
      in_flight = 1'b0;
      n_starts  = 0;
      held      = 0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("result", result, exp_result);
        check("mul_count", n_starts, exp_starts);
        held     = exp_result;
        n_done++;
        n_starts = 0;
      end else begin
        check("result_hold", result, held);
      end
      if (prev_done) check("idle_after_done", busy, 0);
      prev_done = done;
      if (in_flight) begin
        check("operands_stable", {mul_a, mul_b, mul_m}, cap);
        check("busy_in_wait", busy, 1);
        if (mul_done) in_flight = 1'b0;
      end
      if (mul_start) begin
        check("start_while_waiting", in_flight, 0);
        check("mul_m", mul_m, exp_m);
        if (n_starts < 8) begin
          seq_a[n_starts] = mul_a;
          seq_b[n_starts] = mul_b;
        end
        n_starts++;
        cap       = {mul_a, mul_b, mul_m};
        in_flight = 1'b1;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_mul_start", mul_start, 0);
  endtask

  task automatic launch(input int m, input int x, input int e, input int len, input bit hold);
    exp_m      = m;
    exp_result = pow_mod(x, e, len, m);
    exp_starts = eff_len(len) + pop_len(e, len) + 1;
    in_m  = 8'(m);
    in_r  = 8'(256 % m);
    in_x  = 8'((x * 256) % m);
    in_e  = 8'(e);
    e_len = 4'(len);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      start = 1'b0;
      in_m  = 8'($urandom);
      in_r  = 8'($urandom);
      in_x  = 8'($urandom);
      in_e  = 8'($urandom);
      e_len = 4'($urandom);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 6000);
    check("done_timeout", done, 1);
  endtask

  task automatic run_op(input int m, input int x, input int e, input int len);
    int d0 = n_done;
    launch(m, x, e, len, 1'b0);
    wait_done();
    @(negedge clk);
    check("done_once", n_done, d0 + 1);
  endtask

  initial begin : main
    int ea [6] = '{9, 9, 5, 10, 1, 2};
    int eb [6] = '{9, 5, 5, 10, 5, 1};
    int k;
    int m, x;

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Model pins against hand-computed values
    check("pin_mont", mont(9, 9, 13), 9);
    check("pin_pow", pow_mod(2, 5, 3, 13), 6);
    check("pin_pow_clamp", pow_mod(2, 5, 15, 13), 6);

    // Scenario 1: 2^5 mod 13 via S,M,S,S,M,P
    run_op(13, 2, 5, 3);
    check("s1_result", result, 6);
    for (int i = 0; i < 6; i++) begin
      check("s1_seq_a", seq_a[i], ea[i]);
      check("s1_seq_b", seq_b[i], eb[i]);
    end

    // Scenario 2: zero-length and zero exponent
    run_op(13, 2, 5, 0);
    check("s2a_result", result, 1);
    run_op(13, 2, 0, 4);
    check("s2b_result", result, 1);
    // Oversized e_len clamps to the register width
    run_op(13, 2, 5, 15);

    // Scenario 3: start held, spurious mul_done outside waits
    glitch_en = 1'b1;
    launch(13, 2, 5, 3, 1'b1);
    wait_done();
    check("s3_first", result, 6);
    wait_done();
    start = 1'b0;
    check("s3_second", result, 6);
    glitch_en = 1'b0;
    repeat (5) @(negedge clk);
    check("s3_stays_idle", busy, 0);
    check("s3_no_third", n_starts, 0);

    // Scenario 4: reset while the first multiply is outstanding
    launch(13, 2, 5, 3, 1'b0);
    k = 0;
    while (n_starts < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("s4_reach_mul", n_starts, 2);
    @(posedge clk); #1;
    check("s4_busy_before", busy, 1);
    do_reset();
    k = n_done;
    repeat (6) @(negedge clk);
    check("s4_idle", busy, 0);
    check("s4_no_start", n_starts, 0);
    check("s4_no_done", n_done, k);
    run_op(13, 2, 5, 3);
    check("s4_result", result, 6);

    // Scenario 5: random latency, random operands
    lat_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      m = 2 * int'($urandom_range(1, 127)) + 1;
      x = int'($urandom_range(0, m - 1));
      run_op(m, x, int'($urandom_range(0, 255)), int'($urandom_range(0, 8)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
